// File: rtl/pixel_job_scheduler.sv
// Shares NUM_ENGINES iteration engines across one frame: raster-order dispatch, raster-order retire.
// Optional SCHED_STATS_EN adds frame_cycles / stall_cycles counters latched on frame_done.
//
// state   | meaning
// --------+-----------------------------------------------------
// C_IDLE  | waiting for frame_start
// C_RUN   | dispatching jobs, retiring as results arrive
// C_DRAIN | all jobs dispatched, waiting for the last retire
module pixel_job_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int ITER_W      = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          frame_start,
    output logic                          busy,
    output logic                          frame_done,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [15:0]                   eng_x,
    output logic [15:0]                   eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic [ITER_W-1:0]             pix_iter,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_sof,
    output logic                          pix_eol
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                   frame_cycles,
    output logic [31:0]                   stall_cycles
`endif
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [15:0] X_LAST = 16'(X_SIZE - 1);
    localparam logic [15:0] Y_LAST = 16'(Y_SIZE - 1);

    typedef enum logic [1:0] {C_IDLE, C_RUN, C_DRAIN} ctrl_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} slot_t;

    ctrl_t             ctrl_q, ctrl_d;
    slot_t             slot_q   [NUM_ENGINES];
    logic [ITER_W-1:0] result_q [NUM_ENGINES];
    logic [PW-1:0]     d_ptr, r_ptr;
    logic [15:0]       dx, dy, rx, ry;
    logic              dispatch, retire, start_accept;
    logic              last_disp, last_ret;

    assign start_accept = (ctrl_q == C_IDLE) && frame_start;
    assign last_disp    = (dx == X_LAST) && (dy == Y_LAST);
    assign last_ret     = (rx == X_LAST) && (ry == Y_LAST);

    assign busy      = (ctrl_q != C_IDLE);
    assign pix_valid = (slot_q[r_ptr] == S_DONE);
    assign retire    = pix_valid && pix_ready;
    assign pix_iter  = result_q[r_ptr];
    // Flags are qualified by valid so they stay low while nothing is presented.
    assign pix_sof   = pix_valid && (rx == 16'd0) && (ry == 16'd0);
    assign pix_eol   = pix_valid && (rx == X_LAST);
    assign eng_x     = dx;
    assign eng_y     = dy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ctrl_q <= C_IDLE;
        else          ctrl_q <= ctrl_d;
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        dispatch   = 1'b0;
        frame_done = 1'b0;
        case (ctrl_q)
            C_IDLE: begin
                if (frame_start) ctrl_d = C_RUN;
            end
            C_RUN: begin
                dispatch = (slot_q[d_ptr] == S_IDLE);
                if (dispatch && last_disp) ctrl_d = C_DRAIN;
            end
            C_DRAIN: begin
                if (retire && last_ret) begin
                    ctrl_d     = C_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: ctrl_d = C_IDLE;
        endcase
    end

    always_comb begin
        eng_start = '0;
        if (dispatch) eng_start[d_ptr] = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            d_ptr <= '0;
            r_ptr <= '0;
            dx    <= '0;
            dy    <= '0;
            rx    <= '0;
            ry    <= '0;
        end else if (start_accept) begin
            d_ptr <= '0;
            r_ptr <= '0;
            dx    <= '0;
            dy    <= '0;
            rx    <= '0;
            ry    <= '0;
        end else begin
            if (dispatch) begin
                d_ptr <= d_ptr + PW'(1);
                if (dx == X_LAST) begin
                    dx <= '0;
                    dy <= (dy == Y_LAST) ? 16'd0 : dy + 16'd1;
                end else begin
                    dx <= dx + 16'd1;
                end
            end
            if (retire) begin
                r_ptr <= r_ptr + PW'(1);
                if (rx == X_LAST) begin
                    rx <= '0;
                    ry <= (ry == Y_LAST) ? 16'd0 : ry + 16'd1;
                end else begin
                    rx <= rx + 16'd1;
                end
            end
        end
    end

    // Retire, completion and dispatch each act on a distinct slot state, so the
    // priority order below never actually discards an event.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot_q[i]   <= S_IDLE;
                result_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (retire && (r_ptr == PW'(i))) begin
                    slot_q[i] <= S_IDLE;
                end else if (eng_done[i] && (slot_q[i] == S_RUN)) begin
                    slot_q[i]   <= S_DONE;
                    result_q[i] <= eng_iter[i*ITER_W +: ITER_W];
                end else if (dispatch && (d_ptr == PW'(i))) begin
                    slot_q[i] <= S_RUN;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] fc_cnt, st_cnt;
    logic        stall_now;

    assign stall_now = pix_valid && !pix_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fc_cnt       <= '0;
            st_cnt       <= '0;
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else if (start_accept) begin
            fc_cnt <= '0;
            st_cnt <= '0;
        end else if (busy) begin
            if (frame_done) begin
                frame_cycles <= fc_cnt + 32'd1;
                stall_cycles <= st_cnt + {31'd0, stall_now};
            end else begin
                fc_cnt <= fc_cnt + 32'd1;
                if (stall_now) st_cnt <= st_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
